// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch requester, data requester and unified
// memory port signals shared around mem_port_arbiter.
//
// Modports:
//   master - arbiter view: receives requests and memory responses, drives the
//            returned data, rvalid pulses, stalls and the memory request fields.
//   slave  - environment view (requesters plus memory model), the mirror image.
//
// Signal groups:
//   fetch  : i_req, i_addr -> i_rdata, i_rvalid, i_stall
//   data   : d_req, d_we, d_addr, d_wd, d_be -> d_rdata, d_rvalid, d_stall
//   memory : mem_req, mem_we, mem_addr, mem_wd, mem_be <- mem_gnt, mem_rvalid, mem_rd
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_rvalid;
    logic              i_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wd;
    logic [3:0]        d_be;
    logic [31:0]       d_rdata;
    logic              d_rvalid;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic [3:0]        mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rd;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wd, d_be, mem_gnt, mem_rvalid, mem_rd,
        output i_rdata, i_rvalid, i_stall, d_rdata, d_rvalid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wd, mem_be
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wd, d_be, mem_gnt, mem_rvalid, mem_rd,
        input  i_rdata, i_rvalid, i_stall, d_rdata, d_rvalid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wd, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and load/store. One transaction outstanding at a time; data wins contention
// unless it has already taken MAX_D_STREAK consecutive grants while fetch was
// waiting, in which case fetch is forced through.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_port_arbiter_if.master (fetch, data and memory signals)
//   perf_i_stall_cnt / perf_d_stall_cnt : stall-cycle counters, present only
//                when ARB_PERF_CNT_EN is defined
//
// Optional feature macro: ARB_PERF_CNT_EN
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]           perf_i_stall_cnt,
    output logic [31:0]           perf_d_stall_cnt,
`endif
    mem_port_arbiter_if.master    bus
);
    typedef enum logic [1:0] {StIdle, StWaitI, StWaitD} state_e;

    localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

    state_e            state;
    logic [3:0]        streak;
    logic              pick_d;
    logic              pick_i;
    logic [ADDR_W-1:0] sel_addr;

    // Selection is combinational so a request can issue in the same cycle it
    // appears; it only exists in IDLE, so WAIT states never present mem_req.
    always_comb begin
        pick_d   = (state == StIdle) && bus.d_req && (!bus.i_req || (streak < MaxStreak));
        pick_i   = (state == StIdle) && bus.i_req && !pick_d;
        sel_addr = '0;
        if (pick_d) begin
            sel_addr = bus.d_addr;
        end else if (pick_i) begin
            sel_addr = bus.i_addr;
        end
    end

    assign bus.mem_req  = pick_d | pick_i;
    assign bus.mem_we   = pick_d & bus.d_we;
    assign bus.mem_addr = sel_addr;
    assign bus.mem_wd   = pick_d ? bus.d_wd : 32'h0;
    assign bus.mem_be   = pick_d ? bus.d_be : (pick_i ? 4'hF : 4'h0);

    assign bus.i_stall  = bus.i_req && !bus.i_rvalid;
    assign bus.d_stall  = bus.d_req && !bus.d_rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            streak       <= 4'd0;
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.i_rdata  <= 32'h0;
            bus.d_rdata  <= 32'h0;
        end else begin
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;

            case (state)
                StIdle: begin
                    // mem_rvalid here has no owner and is dropped.
                    if (bus.mem_gnt && pick_d) begin
                        state <= StWaitD;
                    end else if (bus.mem_gnt && pick_i) begin
                        state <= StWaitI;
                    end
                end
                StWaitI: begin
                    if (bus.mem_rvalid) begin
                        bus.i_rdata  <= bus.mem_rd;
                        bus.i_rvalid <= 1'b1;
                        state        <= StIdle;
                    end
                end
                StWaitD: begin
                    // Store acks also land here; d_rdata takes whatever mem_rd carries.
                    if (bus.mem_rvalid) begin
                        bus.d_rdata  <= bus.mem_rd;
                        bus.d_rvalid <= 1'b1;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // Streak counts data grants that bypassed a waiting fetch.
            if (!bus.i_req) begin
                streak <= 4'd0;
            end else if (bus.mem_gnt && pick_i) begin
                streak <= 4'd0;
            end else if (bus.mem_gnt && pick_d && (streak < MaxStreak)) begin
                streak <= streak + 4'd1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_i_stall_cnt <= 32'h0;
            perf_d_stall_cnt <= 32'h0;
        end else begin
            if (bus.i_stall) perf_i_stall_cnt <= perf_i_stall_cnt + 32'h1;
            if (bus.d_stall) perf_d_stall_cnt <= perf_d_stall_cnt + 32'h1;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester and the load/store (data) requester.
- Sits between fetch/memory stages and the single-ported memory.
- Generates per-requester stall signals.
- Routes returned read data to whichever requester owns the current transaction.
- Allows one outstanding transaction at a time; data has priority, with a starvation guard for fetch.

Parameters:
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending before fetch is forced (1..15).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held until i_rvalid
- i_addr  in  ADDR_W  fetch address (word aligned)
- i_rdata  out  32  fetched instruction
- i_rvalid  out  1  one-cycle pulse, i_rdata valid
- i_stall  out  1  fetch must hold PC
- d_req  in  1  data request; held until d_rvalid
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wd  in  32  store data
- d_be  in  4  byte enables
- d_rdata  out  32  load data
- d_rvalid  out  1  one-cycle pulse, load data valid or store done
- d_stall  out  1  memory stage must hold
- mem_req  out  1  request to memory
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wd  out  32  write data
- mem_be  out  4  byte enables (4'hF for fetch)
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  response valid (read data or write ack)
- mem_rd  in  32  read data

Behaviour:
- States: IDLE, WAIT_I, WAIT_D.
- Reset: state=IDLE, streak=0; i_rvalid=d_rvalid=0; i_rdata=d_rdata=0; mem_req=0.
- IDLE selection is combinational, giving zero-cycle issue:
  - Pick data if d_req && (!i_req || streak<MAX_D_STREAK).
  - Else pick fetch if i_req.
  - Else mem_req=0.
- mem_* signals mirror the selected requester's fields. For fetch: mem_we=0, mem_be=4'hF, mem_wd=0.
- mem_req is held, with stable fields, until mem_gnt. The selection may change only while mem_gnt is low and inputs change.
- IDLE & mem_gnt: next state is WAIT_D or WAIT_I.
- WAIT_x:
  - mem_req=0; further requests are not issued.
  - On mem_rvalid: register mem_rd into x_rdata, pulse x_rvalid for exactly one cycle (next cycle), return to IDLE.
  - x_rdata holds its value until the next response for x.
- Latency: grant at cycle N, mem_rvalid at cycle M gives x_rvalid high at cycle M+1. Minimum request-to-rvalid is 2 cycles (gnt at N, rvalid N+1).
- Back-to-back: the IDLE cycle that contains an x_rvalid pulse may issue the next request.
- Stalls: i_stall = i_req && !i_rvalid; d_stall = d_req && !d_rvalid.
- Streak counter (4 bits):
  - +1 on each data grant while i_req=1.
  - Cleared on fetch grant, or in any cycle with i_req=0.
  - Saturates at MAX_D_STREAK.
- Simultaneous i_req & d_req with streak<MAX: data wins. At streak==MAX: fetch wins, and streak clears on its grant.
- mem_rvalid in IDLE (stray, or arriving after reset) is ignored; no rvalid pulse.
- Reset mid-transaction: return to IDLE, drop ownership. Requesters re-issue after reset.
- Stores: d_rvalid is pulsed on the write ack. d_rdata is updated with mem_rd (don't-care value).

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds outputs perf_i_stall_cnt[31:0] and perf_d_stall_cnt[31:0].
  - Each increments on every cycle its stall is high; wraps at 2^32.
  - Cleared by reset.
- When undefined, those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_gnt same cycle, mem_rvalid next cycle with mem_rd=0x00500093 -> mem_addr=0x100, mem_be=4'hF; i_rvalid pulses 1 cycle with i_rdata=0x00500093; i_stall low after.
- Contention: i_req=d_req=1 (d_addr=0x2000, load), streak=0 -> data issued first, d_rvalid, then fetch issued; i_stall high throughout data transaction.
- Starvation: d_req held continuously with new loads, i_req=1, MAX_D_STREAK=4 -> exactly 4 data grants, then fetch granted; streak back to 0.
- Store: d_we=1, d_addr=0x3004, d_wd=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 with same fields; d_rvalid on ack; no i_rvalid.
- Slow memory: mem_gnt low 3 cycles -> mem_req and fields stable for all 3 cycles; no state change; stalls high.
- Reset mid-op: reset in WAIT_D, mem_rvalid arrives cycle after reset deasserts -> no d_rvalid; state IDLE; all outputs at reset values.
